// File: rtl/capture_sequencer.sv
// capture_sequencer: run-level controller for the logic-analyser capture path.
// Arms the engine, enforces the trigger timeout and gates whole runs to the DMA.
module capture_sequencer #(
  parameter int dataw   = 32,
  parameter int saddr_w = 24,
  parameter int runs_w  = 8,
  parameter int tmo_w   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [runs_w-1:0]  run_count,
  input  logic [saddr_w-1:0] buffer_size,
  input  logic [tmo_w-1:0]   timeout_cycles,
  output logic               cap_arm,
  output logic               cap_abort,
  input  logic               cap_armed,
  input  logic               cap_triggered,
  input  logic               cap_done,
  input  logic [dataw-1:0]   s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [dataw-1:0]   m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy,
  output logic [runs_w-1:0]  run_idx,
  output logic               run_irq,
  output logic               seq_done,
  output logic               timed_out,
  output logic               cfg_err
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_ARMED,
    WAIT_TRIG,
    WAIT_DONE,
    DRAIN,
    ABORT
  } state_t;

  state_t state;

  logic [saddr_w-1:0] size_q;
  logic [saddr_w-1:0] beat_cnt;
  logic [runs_w-1:0]  runs_q;
  logic [tmo_w-1:0]   tmo_cnt;
  logic               tmo_en;
  logic               stop_pending;

  logic               drain;
  logic               beat;
  logic               last_cnt;
  logic               seq_end;
  logic [runs_w:0]    idx_next;

  assign drain    = (state == DRAIN);
  assign last_cnt = (beat_cnt == size_q - saddr_w'(1));
  assign beat     = drain & s_tvalid & m_tready;
  assign idx_next = {1'b0, run_idx} + (runs_w + 1)'(1);

  // A stop seen on the final beat ends the sequence just like a pending one.
  assign seq_end  = stop | stop_pending |
                    ((runs_q != '0) && (idx_next == {1'b0, runs_q}));

  assign s_tready = drain & m_tready;
  assign m_tvalid = drain & s_tvalid;
  assign m_tlast  = drain & s_tvalid & last_cnt;
  assign m_tdata  = drain ? s_tdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      size_q       <= '0;
      beat_cnt     <= '0;
      runs_q       <= '0;
      tmo_cnt      <= '0;
      tmo_en       <= 1'b0;
      stop_pending <= 1'b0;
      cap_arm      <= 1'b0;
      cap_abort    <= 1'b0;
      busy         <= 1'b0;
      run_idx      <= '0;
      run_irq      <= 1'b0;
      seq_done     <= 1'b0;
      timed_out    <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cap_arm   <= 1'b0;
      cap_abort <= 1'b0;
      run_irq   <= 1'b0;
      seq_done  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            if (buffer_size == '0) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err      <= 1'b0;
              timed_out    <= 1'b0;
              run_idx      <= '0;
              size_q       <= buffer_size;
              runs_q       <= run_count;
              stop_pending <= 1'b0;
              cap_arm      <= 1'b1;
              busy         <= 1'b1;
              state        <= ARM;
            end
          end
        end

        // A stop landing here is carried into the next state.
        ARM: begin
          if (stop) stop_pending <= 1'b1;
          state <= WAIT_ARMED;
        end

        WAIT_ARMED: begin
          if (stop || stop_pending) begin
            cap_abort <= 1'b1;
            state     <= ABORT;
          end else if (cap_armed) begin
            tmo_cnt <= timeout_cycles;
            tmo_en  <= (timeout_cycles != '0);
            state   <= WAIT_TRIG;
          end
        end

        // Trigger wins over expiry landing in the same cycle.
        WAIT_TRIG: begin
          if (stop || stop_pending) begin
            cap_abort <= 1'b1;
            state     <= ABORT;
          end else if (cap_triggered) begin
            state <= WAIT_DONE;
          end else if (tmo_en) begin
            if (tmo_cnt <= tmo_w'(1)) begin
              tmo_cnt   <= '0;
              timed_out <= 1'b1;
              cap_abort <= 1'b1;
              state     <= ABORT;
            end else begin
              tmo_cnt <= tmo_cnt - tmo_w'(1);
            end
          end
        end

        WAIT_DONE: begin
          if (stop || stop_pending) begin
            cap_abort <= 1'b1;
            state     <= ABORT;
          end else if (cap_done) begin
            beat_cnt <= '0;
            state    <= DRAIN;
          end
        end

        DRAIN: begin
          if (stop) stop_pending <= 1'b1;
          if (beat) begin
            if (last_cnt) begin
              run_irq  <= 1'b1;
              beat_cnt <= '0;
              if (runs_q == '0 || run_idx != '1)
                run_idx <= run_idx + runs_w'(1);
              if (seq_end) begin
                stop_pending <= 1'b0;
                seq_done     <= 1'b1;
                busy         <= 1'b0;
                state        <= IDLE;
              end else begin
                cap_arm <= 1'b1;
                state   <= ARM;
              end
            end else begin
              beat_cnt <= beat_cnt + saddr_w'(1);
            end
          end
        end

        ABORT: begin
          if (!cap_armed && !cap_triggered) begin
            stop_pending <= 1'b0;
            seq_done     <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Run-level controller for the logic-analyser capture path. Arms the capture engine, watches it through armed/triggered/done, and applies an optional trigger timeout with abort.
- Gates the sample stream (FIFO master side toward DMA) so exactly buffer_size beats pass per run, and generates tlast on the final beat.
- Supports single, N-shot and continuous runs. Sits between the host register block, the capture engine and the DMA.

Parameters:
- dataw, 32, sample/stream data width
- saddr_w, 24, width of buffer_size and the beat counter
- runs_w, 8, width of run_count and run_idx
- tmo_w, 32, width of the trigger-timeout counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: begin sequence
- stop  in  1  single-cycle pulse: end sequence
- run_count  in  runs_w  runs per sequence; 0 = continuous
- buffer_size  in  saddr_w  samples per run
- timeout_cycles  in  tmo_w  trigger wait limit in clk cycles; 0 = disabled
- cap_arm  out  1  arm pulse to capture engine
- cap_abort  out  1  abort pulse to capture engine
- cap_armed  in  1  capture engine armed
- cap_triggered  in  1  capture engine triggered
- cap_done  in  1  capture engine done
- s_tdata  in  dataw  stream from FIFO
- s_tvalid  in  1  stream from FIFO
- s_tready  out  1  stream to FIFO
- m_tdata  out  dataw  stream to DMA
- m_tvalid  out  1  stream to DMA
- m_tready  in  1  stream from DMA
- m_tlast  out  1  stream to DMA
- busy  out  1  sequence in progress
- run_idx  out  runs_w  runs completed in the current sequence
- run_irq  out  1  1-cycle pulse after each run's last beat
- seq_done  out  1  1-cycle pulse when the sequence ends
- timed_out  out  1  sticky; cleared on the next accepted start
- cfg_err  out  1  sticky; cleared on the next accepted start

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All outputs 0, counters 0, sticky flags cleared.
- States: IDLE, ARM, WAIT_ARMED, WAIT_TRIG, WAIT_DONE, DRAIN, ABORT.
- IDLE:
  - start with buffer_size == 0: set cfg_err, stay in IDLE.
  - Otherwise start: clear run_idx, timed_out and cfg_err, go to ARM.
  - stop is ignored.
- ARM: cap_arm = 1 for exactly one cycle, then WAIT_ARMED.
- WAIT_ARMED: on cap_armed = 1, load the timeout counter with timeout_cycles and go to WAIT_TRIG.
- WAIT_TRIG:
  - Timeout counter decrements each cycle, only when timeout_cycles != 0.
  - cap_triggered = 1 goes to WAIT_DONE. This takes priority over expiry in the same cycle.
  - Counter reaching 0 with no trigger: set timed_out, go to ABORT.
- WAIT_DONE: cap_done = 1 goes to DRAIN with beat counter = 0.
- stop in WAIT_ARMED, WAIT_TRIG or WAIT_DONE goes to ABORT. A stop or timeout arriving in ARM is honoured on the following cycle.
- ABORT:
  - cap_abort = 1 on the entry cycle only.
  - Wait until cap_armed == 0 and cap_triggered == 0, then go to IDLE and pulse seq_done.
  - run_idx is not incremented.
- DRAIN:
  - Outside DRAIN, s_tready = 0 and m_tvalid = 0.
  - In DRAIN, m_tvalid = s_tvalid, s_tready = m_tready, m_tdata = s_tdata. Combinational pass-through, zero latency.
  - A beat is a cycle with s_tvalid & m_tready; it increments the counter.
  - m_tlast = 1 on the beat where counter == buffer_size-1.
  - On that beat:
    - Pulse run_irq and increment run_idx, saturating at all-ones.
    - If stop_pending, or run_count != 0 and run_idx+1 == run_count: go to IDLE and pulse seq_done.
    - Otherwise go to ARM.
  - stop during DRAIN sets stop_pending. The drain always completes so no partial run reaches the DMA. stop_pending clears on entry to IDLE.
- buffer_size and run_count are sampled on start and held internally. Changes mid-sequence have no effect.
- busy = 1 in every state except IDLE.
- start while busy is ignored.
- Continuous mode (run_count == 0): run_idx wraps modulo 2^runs_w, and run_irq still pulses every run.
- m_tlast asserts only together with m_tvalid.

Test Plan:
- Single run: run_count = 1, buffer_size = 4, timeout 0; capture model asserts armed → triggered → done; DMA always ready → cap_arm pulses once, 4 beats pass, tlast on beat 4, one run_irq, seq_done, busy back to 0, run_idx = 1.
- Back-pressure: buffer_size = 8, m_tready toggled every other cycle, s_tvalid random → exactly 8 beats with data in order, tlast only on beat 8, s_tready never high outside DRAIN.
- Timeout: timeout_cycles = 10, trigger never asserts → cap_abort pulse about 10 cycles after armed; timed_out = 1; IDLE after cap_armed falls; run_idx = 0; no beats accepted.
- N-shot: run_count = 3, buffer_size = 2 → three cap_arm pulses, six beats, three tlasts, three run_irq, single seq_done, run_idx = 3.
- Stop in each phase: continuous mode, stop in WAIT_TRIG → abort with no data. Stop mid-DRAIN at beat 2 of 4 → remaining 2 beats delivered with tlast, then IDLE, no further cap_arm.
- Config/reset: start with buffer_size = 0 → cfg_err = 1, busy stays 0. Reset low mid-DRAIN → all outputs 0 immediately, s_tready = 0.
